// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus responder: command encodings, address map,
// FSM states and the command decoder.
package lcd1602_pkg;

    localparam int CMD_CLEAR_BIT   = 0;
    localparam int CMD_HOME_BIT    = 1;
    localparam int CMD_ENTRY_BIT   = 2;
    localparam int CMD_DISPLAY_BIT = 3;
    localparam int CMD_SHIFT_BIT   = 4;
    localparam int CMD_FUNC_BIT    = 5;
    localparam int CMD_CGRAM_BIT   = 6;
    localparam int CMD_DDRAM_BIT   = 7;

    localparam logic [7:0] CMD_CLEAR   = 8'(1 << CMD_CLEAR_BIT);
    localparam logic [7:0] CMD_HOME    = 8'(1 << CMD_HOME_BIT);
    localparam logic [7:0] CMD_ENTRY   = 8'(1 << CMD_ENTRY_BIT);
    localparam logic [7:0] CMD_DISPLAY = 8'(1 << CMD_DISPLAY_BIT);
    localparam logic [7:0] CMD_SHIFT   = 8'(1 << CMD_SHIFT_BIT);
    localparam logic [7:0] CMD_FUNC    = 8'(1 << CMD_FUNC_BIT);
    localparam logic [7:0] CMD_CGRAM   = 8'(1 << CMD_CGRAM_BIT);
    localparam logic [7:0] CMD_DDRAM   = 8'(1 << CMD_DDRAM_BIT);

    localparam logic [6:0] LINE0_END   = 7'h27;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h67;
    localparam int         DDRAM_DEPTH = 80;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEARING,
        ST_BUSY
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPLAY,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } cmd_op_t;

    // The highest set bit of the instruction byte selects the command.
    function automatic cmd_op_t decode_cmd(input logic [7:0] d);
        if ((d & CMD_DDRAM) != 8'h00)   return OP_DDRAM;
        if ((d & CMD_CGRAM) != 8'h00)   return OP_CGRAM;
        if ((d & CMD_FUNC) != 8'h00)    return OP_FUNC;
        if ((d & CMD_SHIFT) != 8'h00)   return OP_SHIFT;
        if ((d & CMD_DISPLAY) != 8'h00) return OP_DISPLAY;
        if ((d & CMD_ENTRY) != 8'h00)   return OP_ENTRY;
        if ((d & CMD_HOME) != 8'h00)    return OP_HOME;
        if ((d & CMD_CLEAR) != 8'h00)   return OP_CLEAR;
        return OP_NONE;
    endfunction

    // Linear RAM index (0..79) back to a two-line address counter value.
    function automatic logic [6:0] lin_to_ac(input logic [6:0] idx);
        return (idx <= LINE0_END) ? idx : idx + (LINE1_BASE - LINE0_END - 7'd1);
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM addressed by the two-line AC map; port A combinational read/sync write
// for the core, port B registered read for debug/mirror access.
module lcd_ddram
    import lcd1602_pkg::*;
(
    input  logic       clk,
    input  logic       a_we,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    input  logic [6:0] b_addr,
    output logic [7:0] b_rdata
);

    logic [7:0] mem [DDRAM_DEPTH];
    logic [6:0] a_idx;
    logic [6:0] b_idx;

    function automatic logic [6:0] ac_to_index(input logic [6:0] a);
        return (a < LINE1_BASE) ? a : a - (LINE1_BASE - LINE0_END - 7'd1);
    endfunction

    assign a_idx   = ac_to_index(a_addr);
    assign b_idx   = ac_to_index(b_addr);
    assign a_rdata = (a_idx < 7'(DDRAM_DEPTH)) ? mem[a_idx] : 8'h00;

    always_ff @(posedge clk) begin
        if (a_we && (a_idx < 7'(DDRAM_DEPTH)))
            mem[a_idx] <= a_wdata;
        b_rdata <= (b_idx < 7'(DDRAM_DEPTH)) ? mem[b_idx] : 8'h00;
    end

endmodule

// File: rtl/lcd1602_responder.sv
// Display-side responder for the HD44780-style 8-bit LCD bus: command decode, DDRAM shadow,
// address counter and busy flag. Optional CGRAM model enabled by defining LCD_CGRAM_EN.
module lcd1602_responder
    import lcd1602_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1520
) (
    input  logic       in_clock,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rw,
    input  logic       lcd_rs,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] ddram_addr,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       err_overrun
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE0_END) return LINE1_BASE;
            if (a == LINE1_END) return 7'h00;
            return a + 7'd1;
        end
        if (a == LINE1_BASE) return LINE0_END;
        if (a == 7'h00)      return LINE1_END;
        return a - 7'd1;
    endfunction

    // Addresses in the gaps of the two-line map saturate onto the next line start.
    function automatic logic [6:0] ac_clamp(input logic [6:0] a);
        if (a > LINE0_END && a < LINE1_BASE) return LINE1_BASE;
        if (a > LINE1_END)                   return 7'h00;
        return a;
    endfunction

    logic [SYNC_STAGES-1:0] e_sync_p, rw_sync_p, rs_sync_p;
    logic [7:0]             d_sync_p [SYNC_STAGES];
    logic                   e_s, rw_s, rs_s, e_prev;
    logic                   rw_l, rs_l;
    logic [7:0]             d_l;

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic [6:0]       clr_idx;
    logic [6:0]       ac;
    logic             id_inc;
    logic             sel_cgram;

    logic       strobe, rise, wr_strobe, wr_accept, data_wr, cmd_wr, rd_data_strobe;
    logic       start_busy, is_clear;
    cmd_op_t    op;
    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata, cg_rdata;

    // Stage p0..pN: metastability chain on the asynchronous bus
    always_ff @(posedge in_clock) begin
        if (rst) begin
            e_sync_p  <= '0;
            rw_sync_p <= '0;
            rs_sync_p <= '0;
        end else begin
            e_sync_p  <= {e_sync_p[SYNC_STAGES-2:0], lcd_e};
            rw_sync_p <= {rw_sync_p[SYNC_STAGES-2:0], lcd_rw};
            rs_sync_p <= {rs_sync_p[SYNC_STAGES-2:0], lcd_rs};
        end
    end

    always_ff @(posedge in_clock) begin
        d_sync_p[0] <= data_in;
        for (int i = 1; i < SYNC_STAGES; i++)
            d_sync_p[i] <= d_sync_p[i-1];
        if (e_s) begin
            rw_l <= rw_s;
            rs_l <= rs_s;
            d_l  <= d_sync_p[SYNC_STAGES-1];
        end
    end

    assign e_s  = e_sync_p[SYNC_STAGES-1];
    assign rw_s = rw_sync_p[SYNC_STAGES-1];
    assign rs_s = rs_sync_p[SYNC_STAGES-1];

    assign strobe         = e_prev && !e_s;
    assign rise           = e_s && !e_prev;
    assign wr_strobe      = strobe && !rw_l;
    assign wr_accept      = wr_strobe && !busy;
    assign op             = decode_cmd(d_l);
    assign data_wr        = wr_accept && rs_l;
    assign cmd_wr         = wr_accept && !rs_l && (op != OP_NONE);
    assign rd_data_strobe = strobe && rw_l && rs_l;
    assign start_busy     = data_wr || cmd_wr;
    assign is_clear       = cmd_wr && (op == OP_CLEAR);

    assign data_oe    = e_s && rw_s;
    assign ddram_addr = ac;

    // Clear owns port A while it sweeps the RAM; otherwise port A follows AC.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ac;
        ram_wdata = d_l;
        if (state == ST_CLEARING) begin
            ram_we    = 1'b1;
            ram_addr  = lin_to_ac(clr_idx);
            ram_wdata = BLANK_CHAR;
        end else if (data_wr && !sel_cgram) begin
            ram_we = 1'b1;
        end
    end

    lcd_ddram u_ddram (
        .clk     (in_clock),
        .a_we    (ram_we),
        .a_addr  (ram_addr),
        .a_wdata (ram_wdata),
        .a_rdata (ram_rdata),
        .b_addr  (rd_addr),
        .b_rdata (rd_data)
    );

`ifdef LCD_CGRAM_EN
    logic [7:0] cgram [64];
    logic [5:0] cg_ptr;

    always_ff @(posedge in_clock) begin
        if (data_wr && sel_cgram)
            cgram[cg_ptr] <= d_l;
    end

    assign cg_rdata = cgram[cg_ptr];
`else
    assign cg_rdata = 8'h00;
`endif

    // Display on/off, cursor, blink, entry shift and function set only affect the glass,
    // so those commands contribute busy timing and nothing else here.
    always_ff @(posedge in_clock) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            busy_cnt    <= '0;
            clr_idx     <= '0;
            ac          <= '0;
            id_inc      <= 1'b1;
            sel_cgram   <= 1'b0;
            err_overrun <= 1'b0;
            data_out    <= '0;
            e_prev      <= 1'b0;
`ifdef LCD_CGRAM_EN
            cg_ptr      <= '0;
`endif
        end else begin
            e_prev <= e_s;

            if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == CNT_W'(1))
                    busy <= 1'b0;
            end

            case (state)
                ST_CLEARING: begin
                    clr_idx <= clr_idx + 7'd1;
                    if (clr_idx == 7'(DDRAM_DEPTH - 1))
                        state <= (busy_cnt <= CNT_W'(1)) ? ST_IDLE : ST_BUSY;
                end
                ST_BUSY: if (busy_cnt <= CNT_W'(1)) state <= ST_IDLE;
                default: ;
            endcase

            if (wr_strobe && busy)
                err_overrun <= 1'b1;

            if (start_busy) begin
                busy     <= 1'b1;
                busy_cnt <= is_clear ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
                state    <= is_clear ? ST_CLEARING : ST_BUSY;
                clr_idx  <= '0;
            end

            if ((data_wr || rd_data_strobe) && !sel_cgram)
                ac <= ac_step(ac, id_inc);
`ifdef LCD_CGRAM_EN
            if ((data_wr || rd_data_strobe) && sel_cgram)
                cg_ptr <= id_inc ? cg_ptr + 6'd1 : cg_ptr - 6'd1;
`endif

            if (cmd_wr) begin
                case (op)
                    OP_CLEAR: begin
                        ac     <= '0;
                        id_inc <= 1'b1;
                    end
                    OP_HOME:  ac <= '0;
                    OP_ENTRY: id_inc <= d_l[1];
                    OP_SHIFT: if (!d_l[3]) ac <= ac_step(ac, d_l[2]);
                    OP_CGRAM: begin
                        sel_cgram <= 1'b1;
`ifdef LCD_CGRAM_EN
                        cg_ptr    <= d_l[5:0];
`endif
                    end
                    OP_DDRAM: begin
                        ac        <= ac_clamp(d_l[6:0]);
                        sel_cgram <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // Status tracks live state for the whole read; data is captured once at E rise.
            if (e_s && rw_s && !rs_s)
                data_out <= {busy, ac};
            else if (rise && rw_s && rs_s)
                data_out <= sel_cgram ? cg_rdata : ram_rdata;
        end
    end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed bench for lcd1602_responder: table of command/data writes with expected AC,
// table of expected DDRAM contents, and hand sequences for clear, overrun, reads and reset.
module tb_lcd1602_responder;

    localparam int BUSY_N  = 40;
    localparam int CLEAR_N = 1520;

    logic       in_clock = 1'b0;
    logic       rst      = 1'b1;
    logic       lcd_e    = 1'b0;
    logic       lcd_rw   = 1'b0;
    logic       lcd_rs   = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic [6:0] rd_addr  = 7'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;
    logic [6:0] ddram_addr;
    logic [7:0] rd_data;
    logic       err_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    lcd1602_responder #(
        .SYNC_STAGES  (2),
        .BUSY_CYCLES  (BUSY_N),
        .CLEAR_CYCLES (CLEAR_N)
    ) dut (
        .in_clock    (in_clock),
        .rst         (rst),
        .lcd_e       (lcd_e),
        .lcd_rw      (lcd_rw),
        .lcd_rs      (lcd_rs),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .busy        (busy),
        .ddram_addr  (ddram_addr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_overrun (err_overrun)
    );

    always #5 in_clock = ~in_clock;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] exp_ac;
    } wvec_t;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] exp;
    } rvec_t;

    wvec_t wv [19];
    rvec_t rv [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic rw, input logic rs, input logic [7:0] d);
        @(negedge in_clock);
        lcd_rw  = rw;
        lcd_rs  = rs;
        data_in = d;
        lcd_e   = 1'b1;
        repeat (4) @(negedge in_clock);
        lcd_e = 1'b0;
    endtask

    // Write, then measure how many cycles busy stays high.
    task automatic write_wait(input logic rs, input logic [7:0] d, output int len);
        int t;
        strobe(1'b0, rs, d);
        t   = 0;
        len = 0;
        while (!busy && t < 10) begin
            @(negedge in_clock);
            t++;
        end
        check("busy_rise", busy, 1);
        while (busy && len < 4000) begin
            len++;
            @(negedge in_clock);
        end
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] dout,
                            output logic oe_hi, output logic oe_lo);
        @(negedge in_clock);
        lcd_rw = 1'b1;
        lcd_rs = rs;
        lcd_e  = 1'b1;
        repeat (5) @(negedge in_clock);
        dout  = data_out;
        oe_hi = data_oe;
        lcd_e = 1'b0;
        repeat (5) @(negedge in_clock);
        oe_lo = data_oe;
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        @(negedge in_clock);
        rd_addr = a;
        repeat (2) @(negedge in_clock);
        v = rd_data;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge in_clock);
            t++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic check_blank(input string tag);
        logic [7:0] v;
        logic [6:0] a;
        for (int i = 0; i < 80; i++) begin
            a = (i < 40) ? 7'(i) : 7'(i + 24);
            peek(a, v);
            check($sformatf("%s_blank_%02h", tag, a), v, 8'h20);
        end
    endtask

    initial begin
        int         len;
        logic [7:0] v;
        logic       oe_hi, oe_lo;

        wv[0]  = '{1'b0, 8'hA6, 7'h26};
        wv[1]  = '{1'b1, 8'h41, 7'h27};
        wv[2]  = '{1'b1, 8'h42, 7'h40};
        wv[3]  = '{1'b1, 8'h43, 7'h41};
        wv[4]  = '{1'b0, 8'h04, 7'h41};
        wv[5]  = '{1'b0, 8'h80, 7'h00};
        wv[6]  = '{1'b1, 8'h5A, 7'h67};
        wv[7]  = '{1'b0, 8'hB0, 7'h40};
        wv[8]  = '{1'b0, 8'hF0, 7'h00};
        wv[9]  = '{1'b0, 8'h06, 7'h00};
        wv[10] = '{1'b0, 8'h14, 7'h01};
        wv[11] = '{1'b0, 8'h10, 7'h00};
        wv[12] = '{1'b0, 8'h10, 7'h67};
        wv[13] = '{1'b0, 8'h02, 7'h00};
        wv[14] = '{1'b0, 8'hE7, 7'h67};
        wv[15] = '{1'b1, 8'h51, 7'h00};
        wv[16] = '{1'b0, 8'h38, 7'h00};
        wv[17] = '{1'b0, 8'h0F, 7'h00};
        wv[18] = '{1'b0, 8'h1C, 7'h00};

        rv[0] = '{7'h26, 8'h41};
        rv[1] = '{7'h27, 8'h42};
        rv[2] = '{7'h40, 8'h43};
        rv[3] = '{7'h00, 8'h5A};
        rv[4] = '{7'h67, 8'h51};
        rv[5] = '{7'h41, 8'h20};

        // Reset state
        repeat (3) @(negedge in_clock);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ac", ddram_addr, 7'h00);
        check("rst_oe", data_oe, 0);
        check("rst_dout", data_out, 8'h00);
        check("rst_err", err_overrun, 0);

        // T1: clear timing and fill
        write_wait(1'b0, 8'h01, len);
        check("clear_busy_len", len, CLEAR_N);
        check("clear_ac", ddram_addr, 7'h00);
        bus_read(1'b0, v, oe_hi, oe_lo);
        check("clear_status", v, 8'h00);
        check_blank("t1");

        // T2/T3 and command coverage: every write checked for busy length and AC
        for (int i = 0; i < 19; i++) begin
            write_wait(wv[i].rs, wv[i].d, len);
            check($sformatf("vec%0d_busy_len", i), len, BUSY_N);
            check($sformatf("vec%0d_ac", i), ddram_addr, wv[i].exp_ac);
            bus_read(1'b0, v, oe_hi, oe_lo);
            check($sformatf("vec%0d_status", i), v, {1'b0, wv[i].exp_ac});
        end
        for (int i = 0; i < 6; i++) begin
            peek(rv[i].addr, v);
            check($sformatf("ram_%02h", rv[i].addr), v, rv[i].exp);
        end

        // T4: second write while busy is dropped and flagged
        write_wait(1'b0, 8'h85, len);
        check("t4_ac_set", ddram_addr, 7'h05);
        strobe(1'b0, 1'b1, 8'h4D);
        repeat (5) @(negedge in_clock);
        strobe(1'b0, 1'b1, 8'h4E);
        bus_read(1'b0, v, oe_hi, oe_lo);
        check("t4_status_busy", v, {1'b1, 7'h06});
        check("t4_status_oe_hi", oe_hi, 1);
        check("t4_status_oe_lo", oe_lo, 0);
        check("t4_err_overrun", err_overrun, 1);
        wait_idle();
        peek(7'h05, v);
        check("t4_ram_05", v, 8'h4D);
        peek(7'h06, v);
        check("t4_ram_06", v, 8'h20);
        check("t4_ac", ddram_addr, 7'h06);

        // T5: data read
        write_wait(1'b0, 8'hC0, len);
        check("t5_ac_set", ddram_addr, 7'h40);
        bus_read(1'b1, v, oe_hi, oe_lo);
        check("t5_rd_data", v, 8'h43);
        check("t5_oe_hi", oe_hi, 1);
        check("t5_oe_lo", oe_lo, 0);
        check("t5_ac_step", ddram_addr, 7'h41);
        check("t5_no_busy", busy, 0);

        // CGRAM selected without CGRAM model: writes discarded, reads zero, AC frozen
        write_wait(1'b0, 8'h40, len);
        check("cg_cmd_busy_len", len, BUSY_N);
        write_wait(1'b1, 8'h58, len);
        check("cg_wr_busy_len", len, BUSY_N);
        check("cg_wr_ac", ddram_addr, 7'h41);
        bus_read(1'b1, v, oe_hi, oe_lo);
        check("cg_rd_data", v, 8'h00);
        check("cg_rd_ac", ddram_addr, 7'h41);
        write_wait(1'b0, 8'hC1, len);
        peek(7'h41, v);
        check("cg_ram_41", v, 8'h20);

        // T6: reset mid-clear aborts, fresh clear completes
        strobe(1'b0, 1'b0, 8'h01);
        repeat (5) @(negedge in_clock);
        bus_read(1'b0, v, oe_hi, oe_lo);
        check("t6_status_clearing", v, 8'h80);
        repeat (12) @(negedge in_clock);
        rst = 1'b1;
        @(negedge in_clock);
        rst = 1'b0;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ac", ddram_addr, 7'h00);
        check("t6_rst_err", err_overrun, 0);
        peek(7'h67, v);
        check("t6_ram_67_kept", v, 8'h51);
        write_wait(1'b0, 8'h01, len);
        check("t6_clear_busy_len", len, CLEAR_N);
        check_blank("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
